vga_capture: RTL and testbench

- VGA sink that samples HSync, VSync and 4:4:4 RGB on the pixel clock.
- Recovers horizontal and vertical position, locks to the incoming frame timing, and emits the active-area pixels with coordinates.
- Reports sync timing violations.
- Sits on the receive side of the VGA link, opposite the VGA controller output. Used for loopback capture and as a self-checking sink in system tests.

---
 rtl/vga_capture_if.sv | 27 ++
 rtl/vga_capture.sv | 108 ++++++++++
 tb/tb_vga_capture.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// vga_capture_if: VGA receive-side bundle (sync/colour in, captured pixels and status out)
// master: drives HSync, VSync, RED, GREEN, BLUE; observes the capture outputs
// slave:  the capture block; samples video, drives pix_*, frame_start, locked, *_err
interface vga_capture_if;
  logic        HSync;
  logic        VSync;
  logic [3:0]  RED;
  logic [3:0]  GREEN;
  logic [3:0]  BLUE;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_data;
  logic        frame_start;
  logic        locked;
  logic        hs_err;
  logic        vs_err;
  logic        blank_err;
  modport master (
    output HSync, VSync, RED, GREEN, BLUE,
    input  pix_valid, pix_x, pix_y, pix_data, frame_start, locked, hs_err, vs_err, blank_err
  );
  modport slave (
    input  HSync, VSync, RED, GREEN, BLUE,
    output pix_valid, pix_x, pix_y, pix_data, frame_start, locked, hs_err, vs_err, blank_err
  );
endinterface

// File: rtl/vga_capture.sv
// vga_capture: VGA sink that recovers position, locks to frame timing and emits active pixels
// clk/rst_n: pixel clock, async active-low reset
// vif (slave): HSync/VSync/RED/GREEN/BLUE in; pix_valid/pix_x/pix_y/pix_data, frame_start,
//   locked, hs_err, vs_err, blank_err out
// Optional: define VGA_CAP_BLANK_CHECK_EN to flag nonzero colour in blanking while locked
module vga_capture #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input logic clk,
  input logic rst_n,
  vga_capture_if.slave vif
);
  localparam logic [9:0] HA0     = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA1     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VA0     = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA1     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0] HS_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] VS_LAST = 10'(V_SYNC - 1);
  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;
  state_t state;
  logic hs1, hs2, vs1, vs2;
  logic [11:0] rgb1, rgb2;
  logic [9:0] hcnt, vcnt;
  logic h_seen, v_seen, frame_err;
  logic hs_fall, hs_rise, vs_fall, vs_rise, h_bad, v_bad, err, active;
  // hcnt/vcnt describe the s2 sample; edges compare s1 against s2. Checks are
  // suppressed until the matching sync edge has been seen since reset/unlock.
  always_comb begin
    hs_fall = hs2 & ~hs1;
    hs_rise = ~hs2 & hs1;
    vs_fall = vs2 & ~vs1;
    vs_rise = ~vs2 & vs1;
    h_bad   = h_seen & ((hs_rise & (hcnt != HS_LAST)) | (hs_fall & (hcnt != H_LAST)));
    v_bad   = v_seen & ((vs_rise & (vcnt != VS_LAST)) | (vs_fall & (vcnt != V_LAST)));
    err     = h_bad | v_bad;
    active  = (hcnt >= HA0) & (hcnt < HA1) & (vcnt >= VA0) & (vcnt < VA1);
  end
  assign vif.locked = state == LOCKED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {hs1, hs2, vs1, vs2} <= '1;
      {rgb1, rgb2}         <= '0;
      {hcnt, vcnt}         <= '0;
      {h_seen, v_seen}     <= '0;
      frame_err            <= 1'b0;
      state                <= UNLOCKED;
      vif.frame_start      <= 1'b0;
      vif.hs_err           <= 1'b0;
      vif.vs_err           <= 1'b0;
      vif.pix_valid        <= 1'b0;
      vif.pix_x            <= '0;
      vif.pix_y            <= '0;
      vif.pix_data         <= '0;
    end else begin
      hs1             <= vif.HSync;
      hs2             <= hs1;
      vs1             <= vif.VSync;
      vs2             <= vs1;
      rgb1            <= {vif.RED, vif.GREEN, vif.BLUE};
      rgb2            <= rgb1;
      hcnt            <= hs_fall ? '0 : hcnt + {9'd0, ~&hcnt};
      vcnt            <= vs_fall ? '0 : vcnt + {9'd0, hs_fall & ~&vcnt};
      vif.hs_err      <= h_bad;
      vif.vs_err      <= v_bad;
      vif.frame_start <= 1'b0;
      h_seen          <= h_seen | hs_fall;
      v_seen          <= v_seen | vs_fall;
      case (state)
        UNLOCKED: if (vs_fall) begin
          state     <= CHECK;
          frame_err <= 1'b0;
        end
        CHECK: if (vs_fall) begin
          if (!(frame_err | err)) begin
            state           <= LOCKED;
            vif.frame_start <= 1'b1;
          end
          frame_err <= 1'b0;
        end else frame_err <= frame_err | err;
        LOCKED: if (err) begin
          state  <= UNLOCKED;
          h_seen <= 1'b0;
          v_seen <= 1'b0;
        end else if (vs_fall) vif.frame_start <= 1'b1;
        default: state <= UNLOCKED;
      endcase
      vif.pix_valid <= (state == LOCKED) & active;
      vif.pix_x     <= hcnt - HA0;
      vif.pix_y     <= 9'(vcnt - VA0);
      vif.pix_data  <= rgb2;
    end
`ifdef VGA_CAP_BLANK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vif.blank_err <= 1'b0;
    else vif.blank_err <= (state == LOCKED) & ~active & (|rgb2);
`else
  assign vif.blank_err = 1'b0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized/directed check of vga_capture against a timestamp-based timing model
module tb_vga_capture;
  localparam int HS = 4, HBP = 3, HA = 8, HFP = 3;
  localparam int VS = 2, VBP = 3, VA = 5, VFP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int HS0 = HS + HBP;
  localparam int VS0 = VS + VBP;
`ifdef VGA_CAP_BLANK_CHECK_EN
  localparam bit BL_EN = 1'b1;
`else
  localparam bit BL_EN = 1'b0;
`endif
  logic clk, rst_n;
  vga_capture_if vif();
  vga_capture #(.H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
                .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP))
    dut (.clk(clk), .rst_n(rst_n), .vif(vif.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int tests, fails;
  int t, last_hf, nlines, vlow, mline, m;
  bit phs, pvs, hs_seen, vs_seen, ferr, probe;
  int probe_t;
  int npix, nhs, nvs, nfs, nbl;
  logic [18:0] first_xy, last_xy;
  logic [3:0]  qf[$];
  logic [32:0] qp[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0d got %0h exp %0h", tag, t, got, exp);
    end
  endtask
  task automatic clr();
    npix = 0; nhs = 0; nvs = 0; nfs = 0; nbl = 0;
  endtask
  task automatic model_reset();
    m = 0; ferr = 0; hs_seen = 0; vs_seen = 0; phs = 1; pvs = 1;
    last_hf = t; nlines = 0; vlow = 0; mline = 0;
    qf.delete(); qp.delete();
    repeat (2) qf.push_back('0);
    repeat (3) qp.push_back('0);
  endtask
  task automatic step(input logic hs, input logic vs, input logic [11:0] rgb);
    logic [3:0] ef;
    logic [32:0] ep;
    bit hf, hr, vf, vr, he, ve, fs, act, bl;
    int col;
    @(negedge clk);
    ef = qf.pop_front();
    ep = qp.pop_front();
    chk("flags", {28'd0, vif.locked, vif.frame_start, vif.hs_err, vif.vs_err}, {28'd0, ef});
    chk("pix_valid", {31'd0, vif.pix_valid}, {31'd0, ep[32]});
    chk("blank_err", {31'd0, vif.blank_err}, {31'd0, ep[31]});
    if (ep[32]) chk("pix", {1'b0, vif.pix_x, vif.pix_y, vif.pix_data}, {1'b0, ep[30:0]});
    if (t == probe_t + 3)
      chk("latency", {vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_data}, {1'b1, 10'd0, 9'd0, 12'hABC});
    if (vif.pix_valid) begin
      if (npix == 0) first_xy = {vif.pix_x, vif.pix_y};
      last_xy = {vif.pix_x, vif.pix_y};
      npix++;
    end
    nhs += int'(vif.hs_err); nvs += int'(vif.vs_err);
    nfs += int'(vif.frame_start); nbl += int'(vif.blank_err);
    vif.HSync = hs; vif.VSync = vs;
    {vif.RED, vif.GREEN, vif.BLUE} = rgb;
    hf = phs & ~hs; hr = ~phs & hs; vf = pvs & ~vs; vr = ~pvs & vs;
    he = hs_seen && ((hr && t - last_hf != HS) || (hf && t - last_hf != HT));
    ve = vs_seen && ((vr && vlow != VS) || (vf && nlines != VT));
    if (hf) begin last_hf = t; hs_seen = 1; end
    if (vf) begin nlines = 0; vlow = 0; mline = 0; vs_seen = 1; end
    if (hf) begin
      nlines++;
      if (!vs) vlow++;
      if (!vf) mline++;
    end
    fs = 0;
    if (m == 2) begin
      if (he || ve) begin m = 0; hs_seen = 0; vs_seen = 0; end
      else if (vf) fs = 1;
    end else if (m == 1) begin
      if (vf) begin
        if (!ferr && !he && !ve) begin m = 2; fs = 1; end
        ferr = 0;
      end else if (he || ve) ferr = 1;
    end else if (vf) begin
      m = 1; ferr = 0;
    end
    col = t - last_hf;
    act = col >= HS0 && col < HS0 + HA && mline >= VS0 && mline < VS0 + VA;
    bl = BL_EN && m == 2 && !act && rgb != 0;
    qf.push_back({m == 2, fs, he, ve});
    qp.push_back({m == 2 && act, bl, 10'(col - HS0), 9'(mline - VS0), rgb});
    phs = hs; pvs = vs; t++;
  endtask
  task automatic do_reset();
    chk("pre_reset_locked", {31'd0, vif.locked}, {31'd0, m == 2});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {30'd0, vif.pix_valid, vif.locked}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    clr();
  endtask
  task automatic run_frame(input int nl, input int bad_line, input int bad_w,
                           input int blank_line, input int rst_line, input bit rnd);
    logic [11:0] rgb;
    int x, y;
    for (int l = 0; l < nl; l++)
      for (int c = 0; c < HT; c++) begin
        if (l == rst_line && c == 10) do_reset();
        x = c - HS0; y = l - VS0;
        rgb = (x >= 0 && x < HA && y >= 0 && y < VA) ? (rnd ? 12'($urandom) : 12'(y * HA + x)) : 12'h0;
        if (l == blank_line && c == 2) rgb = 12'h100;
        if (probe && x == 0 && y == 0) begin rgb = 12'hABC; probe_t = t; end
        step(c >= (l == bad_line ? bad_w : HS), l >= VS, rgb);
      end
  endtask
  initial begin
    tests = 0; fails = 0; t = 0; probe = 0; probe_t = -100;
    rst_n = 1'b0;
    vif.HSync = 1'b1; vif.VSync = 1'b1; vif.RED = '0; vif.GREEN = '0; vif.BLUE = '0;
    clr();
    repeat (2) @(posedge clk);
    #2 chk("reset_state", {vif.pix_valid, vif.frame_start, vif.locked, vif.hs_err, vif.vs_err,
                           vif.blank_err, vif.pix_x, vif.pix_y, vif.pix_data[7:0]}, 32'd0);
    chk("reset_data", {20'd0, vif.pix_data}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    run_frame(VT, -1, HS, -1, -1, 0);
    chk("unlocked_after_f1", {31'd0, vif.locked}, 32'd0);
    run_frame(VT, -1, HS, -1, -1, 0);
    chk("locked_after_f2", {31'd0, vif.locked}, 32'd1);
    clr(); probe = 1;
    run_frame(VT, -1, HS, -1, -1, 0);
    probe = 0;
    chk("f3_pix_count", npix, HA * VA);
    chk("f3_first_xy", {13'd0, first_xy}, 32'd0);
    chk("f3_last_xy", {13'd0, last_xy}, {13'd0, 10'(HA - 1), 9'(VA - 1)});
    chk("f3_errs", nhs + nvs, 0);
    chk("f3_frame_start", nfs, 1);
    clr();
    run_frame(VT, 4, HS - 1, -1, -1, 0);
    chk("hs_short_err", nhs, 1);
    chk("hs_short_unlock", {31'd0, vif.locked}, 32'd0);
    run_frame(VT, -1, HS, -1, -1, 0);
    run_frame(VT, -1, HS, -1, -1, 0);
    chk("relock_hs", {31'd0, vif.locked}, 32'd1);
    run_frame(VT - 1, -1, HS, -1, -1, 0);
    clr();
    run_frame(VT, -1, HS, -1, -1, 0);
    chk("short_frame_vs_err", nvs, 1);
    chk("short_frame_no_fs", nfs, 0);
    chk("short_frame_unlock", {31'd0, vif.locked}, 32'd0);
    run_frame(VT, -1, HS, -1, -1, 0);
    run_frame(VT, -1, HS, -1, -1, 0);
    run_frame(VT, -1, HS, -1, 7, 0);
    run_frame(VT, -1, HS, -1, -1, 0);
    chk("no_pix_after_reset", npix, 0);
    run_frame(VT, -1, HS, -1, -1, 0);
    clr();
    run_frame(VT, -1, HS, 6, -1, 0);
    chk("blank_pulses", nbl, BL_EN ? 1 : 0);
    chk("blank_keeps_lock", {31'd0, vif.locked}, 32'd1);
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 3))
        0: run_frame(VT, -1, HS, -1, -1, 1);
        1: run_frame(VT, int'($urandom_range(0, VT - 1)), $urandom_range(0, 1) ? HS - 1 : HS + 1, -1, -1, 1);
        2: run_frame($urandom_range(0, 1) ? VT - 1 : VT + 1, -1, HS, -1, -1, 1);
        default: run_frame(VT, -1, HS, int'($urandom_range(0, VT - 1)), -1, 1);
      endcase
    end
    repeat (2) run_frame(VT, -1, HS, -1, -1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
